// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop RX synchroniser, mid-bit 3-sample majority vote, per-frame config latch, FIFO of {ferr, perr, data}.
// Latency: an entry is pushed at the vote of the last checked stop bit and shows on m_valid one cycle later.
// Backpressure: m_valid/m_ready pop; a push into a full FIFO with no pop that cycle is dropped and sets sticky overrun.
// Ports: clk/rst (async, active low); baud_div, data_bits, stop_bits and parity are sampled at each start bit;
//   RX is the raw serial line; m_data/m_perr/m_ferr/m_valid/m_ready form the read stream; fifo_level is the entry count;
//   overrun and idle_irq are sticky and cleared by irq_clear; break_det is a one-cycle pulse.
module uart_rx_fifo #(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int IDLE_BITS  = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DIV_W-1:0]                baud_div,
  input  logic [3:0]                      data_bits,
  input  logic [1:0]                      stop_bits,
  input  logic [1:0]                      parity,
  input  logic                            RX,
  output logic [7:0]                      m_data,
  output logic                            m_perr,
  output logic                            m_ferr,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overrun,
  output logic                            break_det,
  output logic                            idle_irq,
  input  logic                            irq_clear
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK_WAIT} state_t;

  state_t r_state, w_next;

  logic             r_sync1, r_sync2, r_rxs_d;
  logic [DIV_W-1:0] r_div, r_bc;
  logic [3:0]       r_nbits;
  logic             r_stop2, r_par_en, r_par_odd;
  logic             r_s0, r_s1;
  logic [2:0]       r_bitidx;
  logic [7:0]       r_data;
  logic             r_pbit, r_perr, r_ferr, r_stop_idx;
  logic [9:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [LW-1:0]    r_level;
  logic             r_overrun, r_break, r_idle_irq, r_idle_arm;
  logic [31:0]      r_idle_cnt;

  logic             w_rxs, w_start, w_decide, w_vote, w_push, w_break;
  logic             w_pop, w_full, w_wr, w_ovr_set, w_idle_set, w_last_data;
  logic [DIV_W-1:0] w_half;
  logic [9:0]       w_entry, w_head;
  logic [31:0]      w_idle_target;

  assign w_rxs       = r_sync2;
  assign w_start     = (r_state == S_IDLE) && r_rxs_d && !w_rxs;
  assign w_half      = r_div >> 1;
  assign w_decide    = (r_bc == w_half + DIV_W'(1));
  // At the decision point the third sample is the live synchronised value.
  assign w_vote      = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
  assign w_last_data = ({1'b0, r_bitidx} == r_nbits - 4'd1);
  assign w_entry     = {r_ferr | ~w_vote, r_perr, r_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync1 <= RX;
      r_sync2 <= r_sync1;
      r_rxs_d <= r_sync2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_push  = 1'b0;
    w_break = 1'b0;
    case (r_state)
      S_IDLE:   if (w_start) w_next = S_START;
      S_START:  if (w_decide) w_next = w_vote ? S_IDLE : S_DATA;
      S_DATA:   if (w_decide && w_last_data) w_next = r_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_decide) w_next = S_STOP;
      S_STOP: begin
        if (w_decide) begin
          if (!r_stop_idx && !w_vote && (r_data == 8'd0) && !r_pbit) begin
            w_break = 1'b1;
            w_next  = S_BREAK_WAIT;
          end else if (!r_stop_idx && r_stop2) begin
            w_next = S_STOP;
          end else begin
            w_push = 1'b1;
            w_next = S_IDLE;
          end
        end
      end
      S_BREAK_WAIT: if (w_rxs) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Bit timing and frame datapath; configuration is captured only at start detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div      <= '0;
      r_bc       <= '0;
      r_nbits    <= 4'd8;
      r_stop2    <= 1'b0;
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
      r_bitidx   <= '0;
      r_data     <= '0;
      r_pbit     <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_stop_idx <= 1'b0;
    end else begin
      if (w_start || (r_bc == r_div - DIV_W'(1))) r_bc <= '0;
      else                                         r_bc <= r_bc + DIV_W'(1);
      if (r_bc == w_half - DIV_W'(1)) r_s0 <= w_rxs;
      if (r_bc == w_half)             r_s1 <= w_rxs;
      if (w_start) begin
        r_div      <= baud_div;
        r_nbits    <= (data_bits >= 4'd5 && data_bits <= 4'd8) ? data_bits : 4'd8;
        r_stop2    <= (stop_bits == 2'b10);
        r_par_en   <= (parity == 2'b01) || (parity == 2'b10);
        r_par_odd  <= (parity == 2'b10);
        r_bitidx   <= '0;
        r_data     <= '0;
        r_pbit     <= 1'b0;
        r_perr     <= 1'b0;
        r_ferr     <= 1'b0;
        r_stop_idx <= 1'b0;
      end else if (w_decide) begin
        case (r_state)
          S_DATA: begin
            r_data[r_bitidx] <= w_vote;
            r_bitidx         <= r_bitidx + 3'd1;
          end
          S_PARITY: begin
            r_pbit <= w_vote;
            // XOR of data and parity bit must be 0 for even, 1 for odd.
            r_perr <= (^r_data) ^ w_vote ^ r_par_odd;
          end
          S_STOP: begin
            r_ferr     <= r_ferr | ~w_vote;
            r_stop_idx <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // FIFO: when full, a push is only taken if the head leaves in the same cycle.
  assign m_valid   = (r_level != '0);
  assign w_pop     = m_valid && m_ready;
  assign w_full    = (r_level == LW'(FIFO_DEPTH));
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_ovr_set = w_push && w_full && !w_pop;
  assign w_head    = r_mem[r_rptr];
  assign m_data    = m_valid ? w_head[7:0] : 8'd0;
  assign m_perr    = m_valid && w_head[8];
  assign m_ferr    = m_valid && w_head[9];
  assign fifo_level = r_level;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= w_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      if (w_wr && !w_pop)      r_level <= r_level + LW'(1);
      else if (!w_wr && w_pop) r_level <= r_level - LW'(1);
    end
  end

  // Idle timeout: counter starts at 1 on the push cycle so the flag is visible IDLE_BITS*div cycles after it.
  assign w_idle_target = 32'(IDLE_BITS) * 32'(r_div);
  assign w_idle_set    = r_idle_arm && !w_push && w_rxs && (r_state == S_IDLE) &&
                         (r_idle_cnt + 32'd1 == w_idle_target);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idle_arm <= 1'b0;
      r_idle_cnt <= '0;
    end else if (w_push) begin
      r_idle_arm <= 1'b1;
      r_idle_cnt <= 32'd1;
    end else if (r_idle_arm) begin
      if (!w_rxs) begin
        r_idle_cnt <= '0;
      end else if (r_state == S_IDLE) begin
        r_idle_cnt <= r_idle_cnt + 32'd1;
        if (w_idle_set) r_idle_arm <= 1'b0;
      end
    end
  end

  // Sticky flags: a set event in the same cycle as irq_clear wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overrun  <= 1'b0;
      r_idle_irq <= 1'b0;
      r_break    <= 1'b0;
    end else begin
      r_break <= w_break;
      if (w_ovr_set)      r_overrun <= 1'b1;
      else if (irq_clear) r_overrun <= 1'b0;
      if (w_idle_set)     r_idle_irq <= 1'b1;
      else if (irq_clear) r_idle_irq <= 1'b0;
    end
  end

  assign overrun   = r_overrun;
  assign break_det = r_break;
  assign idle_irq  = r_idle_irq;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed frames, expected entries queued at send time, monitor pops and compares.
module tb_uart_rx_fifo;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   baud_div;
  logic [3:0]    data_bits;
  logic [1:0]    stop_bits;
  logic [1:0]    parity;
  logic          RX;
  logic [7:0]    m_data;
  logic          m_perr, m_ferr, m_valid, m_ready;
  logic [LW-1:0] fifo_level;
  logic          overrun, break_det, idle_irq, irq_clear;

  uart_rx_fifo #(.DIV_W(16), .FIFO_DEPTH(DEPTH), .IDLE_BITS(10)) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .data_bits(data_bits),
    .stop_bits(stop_bits), .parity(parity), .RX(RX),
    .m_data(m_data), .m_perr(m_perr), .m_ferr(m_ferr), .m_valid(m_valid),
    .m_ready(m_ready), .fifo_level(fifo_level), .overrun(overrun),
    .break_det(break_det), .idle_irq(idle_irq), .irq_clear(irq_clear)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int brk_cnt = 0;
  int valid_rise_cyc = -1;
  int idle_rise_cyc = -1;
  logic prev_valid = 1'b0;
  logic prev_idle = 1'b0;
  logic [9:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: samples between edges, pops the scoreboard on each accepted beat.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        if (m_valid && !prev_valid) valid_rise_cyc = cyc;
        prev_valid = m_valid;
        if (idle_irq && !prev_idle && idle_rise_cyc < 0) idle_rise_cyc = cyc;
        prev_idle = idle_irq;
        if (break_det) brk_cnt++;
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL sb_unexpected_pop: got 0x%0h, expected no entry", {m_ferr, m_perr, m_data});
          end else begin
            check("sb_entry", 32'({m_ferr, m_perr, m_data}), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  task automatic drive_bit(input logic b, input int div);
    RX = b;
    repeat (div) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input bit has_par, input logic pb,
                            input logic sb1, input bit has_sb2, input logic sb2, input int gap_bits);
    int div;
    div = int'(baud_div);
    drive_bit(1'b0, div);
    for (int i = 0; i < nb; i++) drive_bit(d[i], div);
    if (has_par) drive_bit(pb, div);
    drive_bit(sb1, div);
    if (has_sb2) drive_bit(sb2, div);
    for (int i = 0; i < gap_bits; i++) drive_bit(1'b1, div);
  endtask

  task automatic send_8n1(input logic [7:0] d);
    send_frame(d, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2);
  endtask

  task automatic wait_drain(input string nm, input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_clear();
    irq_clear = 1'b1;
    @(negedge clk);
    irq_clear = 1'b0;
    @(negedge clk);
    #1;
  endtask

  initial begin
    int base;
    int n;
    rst = 1'b1; RX = 1'b1; baud_div = 16'd868; data_bits = 4'd8; stop_bits = 2'b00;
    parity = 2'b00; m_ready = 1'b1; irq_clear = 1'b0;
    #2 rst = 1'b0;
    #20;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_flags", 32'({overrun, break_det, idle_irq, m_perr, m_ferr}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // 8N1 at 868 clocks/bit; 0x00 has a high stop bit so it is data, not a break.
    base = brk_cnt;
    exp_q.push_back({2'b00, 8'h55}); send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1);
    exp_q.push_back({2'b00, 8'hA5}); send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1);
    exp_q.push_back({2'b00, 8'h00}); send_frame(8'h00, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1);
    wait_drain("drain_8n1", 2000);
    check("no_break_on_00", 32'(brk_cnt - base), 32'd0);

    // 7E1: 0x41 has two ones, so even parity bit is 0.
    baud_div = 16'd16; data_bits = 4'd7; parity = 2'b01;
    exp_q.push_back({2'b01, 8'h41}); send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2);
    exp_q.push_back({2'b00, 8'h41}); send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2);
    // 5O2: 0x15 has three ones, odd parity bit 0 is correct; second stop bit low -> ferr.
    data_bits = 4'd5; parity = 2'b10; stop_bits = 2'b10;
    exp_q.push_back({2'b10, 8'h15}); send_frame(8'h15, 5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2);
    wait_drain("drain_parity", 200);

    // Overflow: only the first DEPTH bytes are kept.
    data_bits = 4'd8; parity = 2'b00; stop_bits = 2'b00; m_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (i <= DEPTH) exp_q.push_back({2'b00, 8'(i)});
      send_8n1(8'(i));
    end
    #1;
    check("full_level", 32'(fifo_level), 32'(DEPTH));
    check("full_overrun", 32'(overrun), 32'd1);
    check("full_head", 32'(m_data), 32'h01);
    m_ready = 1'b1;
    wait_drain("drain_full", 50);
    check("drained_level", 32'(fifo_level), 32'd0);
    pulse_clear();
    check("overrun_cleared", 32'(overrun), 32'd0);

    // False starts: one-cycle glitch and a 5-cycle (~0.3 bit) low pulse.
    RX = 1'b0; @(negedge clk); RX = 1'b1; repeat (48) @(negedge clk);
    RX = 1'b0; repeat (5) @(negedge clk); RX = 1'b1; repeat (48) @(negedge clk);
    check("glitch_level", 32'(fifo_level), 32'd0);
    exp_q.push_back({2'b00, 8'h3C}); send_8n1(8'h3C);
    wait_drain("drain_3c", 50);

    // Break: 20 bit times low.
    base = brk_cnt;
    RX = 1'b0; repeat (320) @(negedge clk);
    RX = 1'b1; repeat (48) @(negedge clk);
    check("break_pulses", 32'(brk_cnt - base), 32'd1);
    check("break_level", 32'(fifo_level), 32'd0);
    exp_q.push_back({2'b00, 8'h7E}); send_8n1(8'h7E);
    wait_drain("drain_7e", 50);

    // Idle timeout: m_valid rises the cycle after the push cycle, so idle_irq rises 10*868-1 cycles after m_valid.
    repeat (300) @(negedge clk);
    pulse_clear();
    check("idle_cleared", 32'(idle_irq), 32'd0);
    baud_div = 16'd868;
    idle_rise_cyc = -1;
    exp_q.push_back({2'b00, 8'h12});
    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    n = 0;
    while (idle_rise_cyc < 0 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    #2;
    check("idle_irq_delay", 32'(idle_rise_cyc - valid_rise_cyc), 32'd8679);
    check("idle_irq_set", 32'(idle_irq), 32'd1);
    wait_drain("drain_12", 10);

    // Reset mid-frame: stored byte and partial frame are both discarded.
    baud_div = 16'd16; m_ready = 1'b0;
    send_8n1(8'h5A);
    check("pre_rst_level", 32'(fifo_level), 32'd1);
    RX = 1'b0; repeat (40) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_data", 32'(m_data), 32'd0);
    check("mid_rst_flags", 32'({overrun, break_det, idle_irq, m_perr, m_ferr}), 32'd0);
    @(negedge clk);
    RX = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    #1;
    check("post_rst_level", 32'(fifo_level), 32'd0);
    check("post_rst_valid", 32'(m_valid), 32'd0);
    m_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
